stack_port_arbiter: RTL and testbench
=====================================

Name: stack_port_arbiter

Overview:
- Shares port A of the write-first, byte-enabled stack RAM between two requesters:
  - requester 0: pipeline stack unit, priority.
  - requester 1: debug/bus side access.
- Requester 1 gets an anti-starvation guarantee.
- Each accepted access gets exactly one response, tagged to the requester that issued it.
- Out-of-range addresses are rejected. They never reach the RAM.
- Port B of the RAM is not touched by this block.

Parameters:
- DATA_MEM_SIZE_IN_BITS, 10, byte-address width of the stack RAM. Valid address bits are [DATA_MEM_SIZE_IN_BITS-1:0].
- STARVE_LIMIT, 8, consecutive lost cycles of a pending requester 1 before it is forced a grant. Range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 access request.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_we  in  4  byte write enables; 0 = read.
- req0_addr  in  32  byte address.
- req0_wdata  in  32  write data.
- rsp0_valid  out  1  response for requester 0.
- rsp0_rdata  out  32  read data.
- rsp0_err  out  1  address out of range.
- req1_*, rsp1_*  same set, same widths, for requester 1.
- ram_ena  out  1  to RAM ena.
- ram_wea  out  4  to RAM wea.
- ram_addra  out  32  to RAM addra.
- ram_dina  out  32  to RAM dina.
- ram_douta  in  32  from RAM douta; valid 1 cycle after ram_ena.

Behaviour:
- **Reset** (rst_n=0 at a clk edge):
  - starve_cnt=0, resp_owner=none, resp_err=0.
  - rsp0_valid=rsp1_valid=0.
  - Outstanding responses are discarded.
  - req*_ready is forced 0 while rst_n=0.
- **Handshake:**
  - A request is accepted when valid and ready are both 1 in the same cycle.
  - ready is combinational from the grant decision.
  - At most one acceptance per cycle.
  - Requesters hold valid and request fields until accepted.
  - Responses have no backpressure.
- **Grant:**
  - force1 = (starve_cnt == STARVE_LIMIT).
  - grant1 = req1_valid && (!req0_valid || force1).
  - grant0 = req0_valid && !grant1.
- **Starvation counter, 8 bit:**
  - +1 when req1_valid && !grant1.
  - Cleared to 0 when grant1 or !req1_valid.
  - Saturates at STARVE_LIMIT.
- **Range check:** oor = addr[31:DATA_MEM_SIZE_IN_BITS] != 0, evaluated for the granted request.
- **RAM drive (combinational):**
  - ram_ena = (grant0||grant1) && !oor.
  - ram_wea = granted we when ram_ena, else 0.
  - ram_addra and ram_dina are muxed from the granted requester; they are don't-care when ram_ena=0.
- **Response tracking:**
  - On acceptance, register resp_owner = granted id and resp_err = oor. Otherwise resp_owner = none.
  - The next cycle asserts rsp{owner}_valid=1 for exactly one cycle.
  - rsp_rdata = ram_douta when !resp_err, 0 when resp_err.
  - rsp_err = resp_err.
  - The non-owner rsp*_valid=0. rsp*_rdata is 0 when its valid=0.
- **Latency:** fixed 1 cycle from acceptance to response, for reads, writes and errors alike.
  - A write response returns write-first data: the new bytes where we=1 and the old bytes elsewhere.
  - Back-to-back acceptances give back-to-back responses; the pipeline is fully pipelined.
- **Out-of-range request:**
  - Accepted normally.
  - RAM not enabled, memory unchanged.
  - rsp_err=1, rdata=0.
- **Simultaneous request** from both requesters without force1: requester 0 wins, and requester 1 counts one starvation cycle.
- **Reset mid-operation:** an access accepted in the cycle before rst_n falls produces no response. The RAM write itself may complete.

Test Plan:
- Reset, then req0 write we=4'hF addr=0x10 data=0xDEADBEEF; next cycle req0 read 0x10.
  - Write response rsp0_rdata=0xDEADBEEF.
  - Read response one cycle after its acceptance returns 0xDEADBEEF with rsp0_err=0.
- req1 byte write we=4'b0010 addr=0x10 data=0x0000AA00 over the prior word.
  - rsp1_rdata=0xDEADAAEF.
  - rsp0_valid stays 0.
- req0_valid and req1_valid held 1 continuously, STARVE_LIMIT=8.
  - req1 is granted exactly on the 9th cycle, and again every 9 cycles after.
  - req0 gets all other cycles.
- req1 read addr=0x400 (DATA_MEM_SIZE_IN_BITS=10).
  - Accepted with ram_ena=0.
  - Next cycle rsp1_valid=1, rsp1_err=1, rsp1_rdata=0.
  - A subsequent read of word 0x000 is unchanged.
- Back-to-back: req0 read 0x20, req1 read 0x24, req0 read 0x20 on consecutive cycles.
  - Responses arrive on consecutive cycles with correct owner and data.
  - Only one rsp*_valid is high per cycle.
- Assert rst_n=0 the cycle after a req0 acceptance.
  - No rsp0_valid appears.
  - After release, starve_cnt=0 and both readies follow the grant rules.

Source files
------------

// File: rtl/stack_port_arbiter.sv
// Arbiter for port A of the byte-enabled, write-first stack RAM.
// Requester 0 (pipeline) has priority; requester 1 (debug/bus) is protected from starvation.
module stack_port_arbiter #(
    parameter int DATA_MEM_SIZE_IN_BITS = 10,
    parameter int STARVE_LIMIT          = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic        ram_ena,
    output logic [3:0]  ram_wea,
    output logic [31:0] ram_addra,
    output logic [31:0] ram_dina,
    input  logic [31:0] ram_douta
);

    // Handshake: a request is accepted in a cycle where valid and ready are both 1.
    // ready is combinational from the grant; requesters hold valid and fields until
    // accepted. Each acceptance yields exactly one response one cycle later, with
    // no backpressure on the response side.

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_0    = 2'd1;
    localparam logic [1:0] OWNER_1    = 2'd2;

    logic [7:0]  starve_cnt;
    logic [1:0]  resp_owner;
    logic        resp_err;

    logic        force1;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        oor;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign force1 = (starve_cnt == 8'(STARVE_LIMIT));
    assign grant1 = req1_valid && (!req0_valid || force1);
    assign grant0 = req0_valid && !grant1;

    assign req0_ready = rst_n && grant0;
    assign req1_ready = rst_n && grant1;
    assign accept     = req0_ready || req1_ready;

    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

    assign oor = (sel_addr[31:DATA_MEM_SIZE_IN_BITS] != '0);

    // Out-of-range accesses are accepted but never enable the RAM.
    assign ram_ena   = accept && !oor;
    assign ram_wea   = ram_ena ? sel_we : 4'd0;
    assign ram_addra = sel_addr;
    assign ram_dina  = sel_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
            resp_owner <= OWNER_NONE;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                resp_owner <= grant1 ? OWNER_1 : OWNER_0;
                resp_err   <= oor;
            end else begin
                resp_owner <= OWNER_NONE;
                resp_err   <= 1'b0;
            end

            if (!req1_valid || grant1) begin
                starve_cnt <= 8'd0;
            end else if (!force1) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    // Responses are gated by rst_n so an access accepted just before reset never reports.
    assign rsp0_valid = rst_n && (resp_owner == OWNER_0);
    assign rsp1_valid = rst_n && (resp_owner == OWNER_1);
    assign rsp0_err   = rsp0_valid && resp_err;
    assign rsp1_err   = rsp1_valid && resp_err;
    assign rsp0_rdata = (rsp0_valid && !resp_err) ? ram_douta : 32'd0;
    assign rsp1_rdata = (rsp1_valid && !resp_err) ? ram_douta : 32'd0;

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Bench for stack_port_arbiter: directed scenarios plus randomized traffic,
// checked by a reference model feeding an expected-response queue.
module tb_stack_port_arbiter;
    localparam int AW    = 10;
    localparam int LIMIT = 8;
    localparam int WORDS = 1 << (AW - 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_we = 4'd0, req1_we = 4'd0;
    logic [31:0] req0_addr = 32'd0, req1_addr = 32'd0;
    logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        ram_ena;
    logic [3:0]  ram_wea;
    logic [31:0] ram_addra, ram_dina;
    logic [31:0] ram_douta = 32'd0;

    stack_port_arbiter #(.DATA_MEM_SIZE_IN_BITS(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dina(ram_dina), .ram_douta(ram_douta)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Expected response: {owner id, err, rdata}
    logic [33:0] exp_q[$];
    logic [31:0] ram_mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    int          lost = 0;

    logic        last_id;
    logic        last_err;
    logic [31:0] last_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Write-first byte-enabled RAM model on port A
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_ena) begin
            w = merge(ram_mem[ram_addra[AW-1:2]], ram_dina, ram_wea);
            ram_mem[ram_addra[AW-1:2]] = w;
            ram_douta <= w;
        end
    end

    // Monitor: pops the expected queue whenever a response appears
    always @(negedge clk) begin
        logic [33:0] e;
        if (rsp0_valid && rsp1_valid) check("one_rsp_valid", 2'b11, 2'b01);
        if (!rsp0_valid) check("rsp0_idle_rdata", rsp0_rdata, 32'd0);
        if (!rsp1_valid) check("rsp1_idle_rdata", rsp1_rdata, 32'd0);
        if (rsp0_valid || rsp1_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                if (rsp1_valid) begin
                    check("rsp1", {1'b1, rsp1_err, rsp1_rdata}, e);
                    last_id = 1'b1; last_err = rsp1_err; last_data = rsp1_rdata;
                end else begin
                    check("rsp0", {1'b0, rsp0_err, rsp0_rdata}, e);
                    last_id = 1'b0; last_err = rsp0_err; last_data = rsp0_rdata;
                end
            end
        end
    end

    // Driver: one cycle of stimulus; reference model decides the grant and expected response.
    task automatic drive_cycle(
        input logic v0, input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] d0,
        input logic v1, input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] d1,
        output logic r0, output logic r1);
        logic g0, g1, oor;
        logic [3:0] we;
        logic [31:0] a, d, nw;
        @(posedge clk); #1;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        r0 = req0_ready; r1 = req1_ready;
        g1 = v1 && (!v0 || lost == LIMIT);
        g0 = v0 && !g1;
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        if (g0 || g1) begin
            we = g1 ? we1 : we0;
            a  = g1 ? a1  : a0;
            d  = g1 ? d1  : d0;
            oor = (a >= (32'd1 << AW));
            check("ram_ena", ram_ena, !oor);
            if (oor) begin
                exp_q.push_back({g1, 1'b1, 32'd0});
            end else begin
                check("ram_port", {ram_wea, ram_addra, ram_dina}, {we, a, d});
                nw = merge(ref_mem[a[AW-1:2]], d, we);
                ref_mem[a[AW-1:2]] = nw;
                exp_q.push_back({g1, 1'b0, nw});
            end
        end
        if (v1 && !g1) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
        else lost = 0;
    endtask

    task automatic idle(input int n);
        logic r0, r1;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_q.delete();
        lost = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_ready", {req0_ready, req1_ready}, 2'b00);
            check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
            check("rst_ram_ena", ram_ena, 1'b0);
            if (i < n - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        logic r0, r1;
        logic p0, p1;
        logic [3:0] we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int g1_count;

        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end

        apply_reset(3);

        // Full write then read of the same word
        drive_cycle(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, r0, r1);
        drive_cycle(1, 4'h0, 32'h10, 32'h0, 0, 0, 0, 0, r0, r1);
        idle(1); #1;
        check("rd_after_wr", {last_id, last_err, last_data}, {1'b0, 1'b0, 32'hDEADBEEF});

        // Byte write from requester 1 returns write-first merged data
        drive_cycle(0, 0, 0, 0, 1, 4'b0010, 32'h10, 32'h0000AA00, r0, r1);
        idle(1); #1;
        check("byte_wr_rsp1", {last_id, last_err, last_data}, {1'b1, 1'b0, 32'hDEADAAEF});

        // Starvation: req1 forced in on every 9th cycle
        g1_count = 0;
        for (int c = 1; c <= 27; c++) begin
            drive_cycle(1, 0, 32'h20, 0, 1, 0, 32'h24, 0, r0, r1);
            check("starve_grant1", r1, (c % (LIMIT + 1)) == 0);
            if (r1) g1_count++;
        end
        check("starve_count", g1_count, 3);
        idle(2);

        // Out-of-range read is rejected without touching the RAM
        drive_cycle(0, 0, 0, 0, 1, 4'h0, 32'h400, 0, r0, r1);
        idle(1); #1;
        check("oor_rsp1", {last_id, last_err, last_data}, {1'b1, 1'b1, 32'd0});
        drive_cycle(0, 0, 0, 0, 1, 4'hF, 32'h8000_0004, 32'h12345678, r0, r1);
        drive_cycle(1, 4'h0, 32'h0, 0, 0, 0, 0, 0, r0, r1);
        drive_cycle(1, 4'h0, 32'h4, 0, 0, 0, 0, 0, r0, r1);
        idle(1);

        // Back-to-back mixed owners
        drive_cycle(1, 4'hF, 32'h20, 32'h11112222, 0, 0, 0, 0, r0, r1);
        drive_cycle(0, 0, 0, 0, 1, 4'hF, 32'h24, 32'h33334444, r0, r1);
        drive_cycle(1, 4'h0, 32'h20, 0, 0, 0, 0, 0, r0, r1);
        drive_cycle(0, 0, 0, 0, 1, 4'h0, 32'h24, 0, r0, r1);
        drive_cycle(1, 4'h0, 32'h20, 0, 0, 0, 0, 0, r0, r1);
        idle(2);

        // Reset the cycle after an acceptance: its response must vanish
        drive_cycle(1, 4'h0, 32'h10, 0, 0, 0, 0, 0, r0, r1);
        apply_reset(2);
        for (int c = 1; c <= 10; c++) drive_cycle(1, 0, 32'h20, 0, 1, 0, 32'h24, 0, r0, r1);
        idle(2);

        // Randomized traffic with held requests
        p0 = 0; p1 = 0;
        we0 = 0; we1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 9) < 6) begin
                p0 = 1;
                we0 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                a0 = ($urandom_range(0, 9) == 0) ? (32'h400 + {$urandom_range(0, 255), 2'b00})
                                                 : {22'd0, 8'($urandom_range(0, 15)), 2'b00};
                d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 9) < 5) begin
                p1 = 1;
                we1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
                a1 = ($urandom_range(0, 7) == 0) ? {$urandom_range(1, 255), 24'd0}
                                                 : {22'd0, 8'($urandom_range(0, 15)), 2'b00};
                d1 = $urandom;
            end
            drive_cycle(p0, we0, a0, d0, p1, we1, a1, d1, r0, r1);
            if (r0) p0 = 0;
            if (r1) p1 = 0;
        end
        idle(3);
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
